// File: rtl/acc_sequencer_pkg.sv
package acc_sequencer_pkg;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;
  localparam int ARG_W  = 5;
  localparam int WORD_W = 8;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SETI = 3'b001;
  localparam logic [2:0] OP_WAIT = 3'b010;
  localparam logic [2:0] OP_CLR  = 3'b011;
  localparam logic [2:0] OP_JC   = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/acc_sequencer_prog_store.sv
module prog_store
  import acc_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/acc_sequencer.sv
module acc_sequencer
  import acc_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOAD_VALID,
  input  logic [WORD_W-1:0] LOAD_DATA,
  output logic              LOAD_READY,
  input  logic              START,
  input  logic              FLUSH,
  input  logic              CARRY,
  output logic [ARG_W-1:0]  INSTR,
  output logic              WR_EN,
  output logic              DP_CLR,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [AW-1:0]     STEP_ADDR
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [ARG_W-1:0] ARG_ONE = ARG_W'(1);

  state_t            r_state;
  logic [AW:0]       r_count;
  logic [AW-1:0]     r_addr;
  logic [ARG_W-1:0]  r_wait;
  logic [ARG_W-1:0]  r_instr;
  logic              r_wr_en;
  logic              r_dp_clr;
  logic              r_err;

  logic [WORD_W-1:0] w_word;
  logic [2:0]        w_op;
  logic [ARG_W-1:0]  w_arg;
  logic [AW-1:0]     w_tgt;
  logic [AW:0]       w_next_full;
  logic              w_last;
  logic              w_tgt_bad;
  logic              w_idle_like;
  logic              w_load;

  prog_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_store (
    .i_clk   (CLK),
    .i_we    (w_load),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (LOAD_DATA),
    .i_raddr (r_addr),
    .o_rdata (w_word)
  );

  assign w_op        = w_word[OP_MSB:OP_LSB];
  assign w_arg       = w_word[ARG_W-1:0];
  assign w_tgt       = w_arg[AW-1:0];
  assign w_next_full = {1'b0, r_addr} + CNT_ONE;
  assign w_last      = (w_next_full == r_count);
  assign w_tgt_bad   = ({1'b0, w_tgt} >= r_count);
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_load      = LOAD_VALID && LOAD_READY;

  assign LOAD_READY = w_idle_like && (r_count < CNT_MAX);
  assign BUSY       = (r_state == ST_RUN) || (r_state == ST_WAIT);
  assign DONE       = (r_state == ST_DONE);
  assign ERR        = r_err;
  assign INSTR      = r_instr;
  assign WR_EN      = r_wr_en;
  assign DP_CLR     = r_dp_clr;
  assign STEP_ADDR  = r_addr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_addr   <= '0;
      r_wait   <= '0;
      r_instr  <= '0;
      r_wr_en  <= 1'b0;
      r_dp_clr <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_instr  <= '0;
      r_wr_en  <= 1'b0;
      r_dp_clr <= 1'b0;

      if (w_load) r_count <= r_count + CNT_ONE;

      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (FLUSH) begin
            r_count <= '0;
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
          end else if (START) begin
            if (r_count != '0) begin
              r_state <= ST_RUN;
              r_addr  <= '0;
              r_err   <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          // Default: sequential advance; individual opcodes override below.
          if (w_last) r_state <= ST_DONE;
          else        r_addr  <= w_next_full[AW-1:0];

          unique case (w_op)
            OP_NOP: ;
            OP_SETI: begin
              r_instr <= w_arg;
              r_wr_en <= 1'b1;
            end
            OP_WAIT: begin
              // The execute cycle counts as the first of the arg cycles.
              if (w_arg > ARG_ONE) begin
                r_state <= ST_WAIT;
                r_wait  <= w_arg - ARG_ONE;
                r_addr  <= r_addr;
              end
            end
            OP_CLR: r_dp_clr <= 1'b1;
            OP_JC, OP_JMP: begin
              if ((w_op == OP_JMP) || CARRY) begin
                if (w_tgt_bad) begin
                  r_err   <= 1'b1;
                  r_state <= ST_DONE;
                  r_addr  <= r_addr;
                end else begin
                  r_state <= ST_RUN;
                  r_addr  <= w_tgt;
                end
              end
            end
            OP_HALT: begin
              r_state <= ST_DONE;
              r_addr  <= r_addr;
            end
            OP_RSVD: r_err <= 1'b1;
          endcase
        end

        ST_WAIT: begin
          if (r_wait == ARG_ONE) begin
            if (w_last) r_state <= ST_DONE;
            else begin
              r_state <= ST_RUN;
              r_addr  <= w_next_full[AW-1:0];
            end
          end else begin
            r_wait <= r_wait - ARG_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
module tb_acc_sequencer;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] SETI = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] CLR  = 3'd3;
  localparam logic [2:0] JC   = 3'd4;
  localparam logic [2:0] JMP  = 3'd5;
  localparam logic [2:0] HALT = 3'd6;
  localparam logic [2:0] RSVD = 3'd7;

  logic       CLK = 1'b0;
  logic       RESET, LOAD_VALID, START, FLUSH, CARRY;
  logic [7:0] LOAD_DATA;
  logic       LOAD_READY, WR_EN, DP_CLR, BUSY, DONE, ERR;
  logic [4:0] INSTR;
  logic [2:0] STEP_ADDR;

  int errors = 0;
  int checks = 0;
  int busy_cnt;
  logic wr_seen;

  acc_sequencer #(.DEPTH(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_DATA  (LOAD_DATA),
    .LOAD_READY (LOAD_READY),
    .START      (START),
    .FLUSH      (FLUSH),
    .CARRY      (CARRY),
    .INSTR      (INSTR),
    .WR_EN      (WR_EN),
    .DP_CLR     (DP_CLR),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR),
    .STEP_ADDR  (STEP_ADDR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic [2:0] op, input logic [4:0] arg);
    return {op, arg};
  endfunction

  task automatic load(input logic [7:0] w);
    LOAD_VALID = 1'b1;
    LOAD_DATA  = w;
    tick();
    LOAD_VALID = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic pulse_flush();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; LOAD_VALID = 1'b0; LOAD_DATA = '0;
    START = 1'b0; FLUSH = 1'b0; CARRY = 1'b0;
    tick(); tick();
    RESET = 1'b0;

    // Reset state
    chk("rst_instr", {3'b0, INSTR}, 8'h00);
    chk("rst_wr_en", {7'b0, WR_EN}, 8'h00);
    chk("rst_dp_clr", {7'b0, DP_CLR}, 8'h00);
    chk("rst_busy", {7'b0, BUSY}, 8'h00);
    chk("rst_done", {7'b0, DONE}, 8'h00);
    chk("rst_err", {7'b0, ERR}, 8'h00);
    chk("rst_ready", {7'b0, LOAD_READY}, 8'h01);
    chk("rst_addr", {5'b0, STEP_ADDR}, 8'h00);

    // SETI 3, WAIT 4, HALT
    load(mk(SETI, 5'd3));
    load(mk(WAIT, 5'd4));
    load(mk(HALT, 5'd0));
    pulse_start();
    chk("a_busy0", {7'b0, BUSY}, 8'h01);
    chk("a_wr0", {7'b0, WR_EN}, 8'h00);
    chk("a_addr0", {5'b0, STEP_ADDR}, 8'h00);
    tick();
    chk("a_wr1", {7'b0, WR_EN}, 8'h01);
    chk("a_instr1", {3'b0, INSTR}, 8'h03);
    chk("a_addr1", {5'b0, STEP_ADDR}, 8'h01);
    tick();
    chk("a_wr2", {7'b0, WR_EN}, 8'h00);
    chk("a_addr2", {5'b0, STEP_ADDR}, 8'h01);
    busy_cnt = 3;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!BUSY) break;
      busy_cnt++;
    end
    chk("a_busy_cycles", 8'(busy_cnt), 8'd6);
    chk("a_done", {7'b0, DONE}, 8'h01);
    chk("a_err", {7'b0, ERR}, 8'h00);
    chk("a_addr_done", {5'b0, STEP_ADDR}, 8'h02);
    tick();
    chk("a_done_hold", {7'b0, DONE}, 8'h01);

    // JC 2, SETI 7, HALT
    pulse_flush();
    chk("f_done_clr", {7'b0, DONE}, 8'h00);
    chk("f_ready", {7'b0, LOAD_READY}, 8'h01);
    load(mk(JC, 5'd2));
    load(mk(SETI, 5'd7));
    load(mk(HALT, 5'd0));
    CARRY = 1'b1;
    pulse_start();
    wr_seen = WR_EN;
    for (int i = 0; i < 20; i++) begin
      if (DONE) break;
      tick();
      wr_seen = wr_seen | WR_EN;
    end
    chk("jc1_wr_never", {7'b0, wr_seen}, 8'h00);
    chk("jc1_done", {7'b0, DONE}, 8'h01);
    chk("jc1_addr", {5'b0, STEP_ADDR}, 8'h02);
    CARRY = 1'b0;
    pulse_start();
    tick(); tick();
    chk("jc0_wr", {7'b0, WR_EN}, 8'h01);
    chk("jc0_instr", {3'b0, INSTR}, 8'h07);
    chk("jc0_addr", {5'b0, STEP_ADDR}, 8'h02);
    tick();
    chk("jc0_done", {7'b0, DONE}, 8'h01);
    chk("jc0_wr_off", {7'b0, WR_EN}, 8'h00);

    // Full store: NOP, CLR, NOP, RSVD, NOP, NOP, NOP, SETI 9; 9th word dropped
    pulse_flush();
    load(mk(NOP, 5'd0));
    load(mk(CLR, 5'd0));
    load(mk(NOP, 5'd0));
    load(mk(RSVD, 5'd0));
    load(mk(NOP, 5'd0));
    load(mk(NOP, 5'd0));
    load(mk(NOP, 5'd0));
    chk("full_ready7", {7'b0, LOAD_READY}, 8'h01);
    load(mk(SETI, 5'd9));
    chk("full_ready8", {7'b0, LOAD_READY}, 8'h00);
    load(mk(HALT, 5'd0));
    chk("full_ready9", {7'b0, LOAD_READY}, 8'h00);
    pulse_start();
    tick(); tick();
    chk("full_clr", {7'b0, DP_CLR}, 8'h01);
    chk("full_addr2", {5'b0, STEP_ADDR}, 8'h02);
    tick();
    chk("full_clr_off", {7'b0, DP_CLR}, 8'h00);
    tick();
    chk("full_rsvd_err", {7'b0, ERR}, 8'h01);
    chk("full_rsvd_busy", {7'b0, BUSY}, 8'h01);
    tick(); tick(); tick(); tick();
    chk("full_wr", {7'b0, WR_EN}, 8'h01);
    chk("full_instr", {3'b0, INSTR}, 8'h09);
    chk("full_done", {7'b0, DONE}, 8'h01);
    chk("full_addr7", {5'b0, STEP_ADDR}, 8'h07);
    chk("full_err_sticky", {7'b0, ERR}, 8'h01);

    // JMP 5 with count=3
    pulse_flush();
    chk("f2_err_clr", {7'b0, ERR}, 8'h00);
    load(mk(JMP, 5'd5));
    load(mk(NOP, 5'd0));
    load(mk(NOP, 5'd0));
    pulse_start();
    tick();
    chk("jmp_err", {7'b0, ERR}, 8'h01);
    chk("jmp_done", {7'b0, DONE}, 8'h01);
    chk("jmp_busy", {7'b0, BUSY}, 8'h00);
    pulse_start();
    chk("rerun_err_clr", {7'b0, ERR}, 8'h00);
    chk("rerun_busy", {7'b0, BUSY}, 8'h01);
    tick();

    // START with count=0, then FLUSH+START together
    pulse_flush();
    pulse_start();
    chk("empty_err", {7'b0, ERR}, 8'h01);
    chk("empty_busy", {7'b0, BUSY}, 8'h00);
    chk("empty_done", {7'b0, DONE}, 8'h00);
    load(mk(NOP, 5'd0));
    FLUSH = 1'b1; START = 1'b1;
    tick();
    FLUSH = 1'b0; START = 1'b0;
    chk("fs_err", {7'b0, ERR}, 8'h00);
    chk("fs_busy", {7'b0, BUSY}, 8'h00);
    pulse_start();
    chk("fs_count0", {7'b0, ERR}, 8'h01);

    // WAIT 0, WAIT 20, HALT; RESET during the long wait
    pulse_flush();
    load(mk(WAIT, 5'd0));
    load(mk(WAIT, 5'd20));
    load(mk(HALT, 5'd0));
    pulse_start();
    chk("w0_addr0", {5'b0, STEP_ADDR}, 8'h00);
    tick();
    chk("w0_addr1", {5'b0, STEP_ADDR}, 8'h01);
    tick(); tick(); tick();
    chk("w20_busy", {7'b0, BUSY}, 8'h01);
    chk("w20_addr", {5'b0, STEP_ADDR}, 8'h01);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mr_busy", {7'b0, BUSY}, 8'h00);
    chk("mr_addr", {5'b0, STEP_ADDR}, 8'h00);
    chk("mr_ready", {7'b0, LOAD_READY}, 8'h01);
    chk("mr_done", {7'b0, DONE}, 8'h00);
    pulse_start();
    chk("mr_count0", {7'b0, ERR}, 8'h01);
    chk("mr_idle", {7'b0, BUSY}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
